// File: rtl/pc_seq_if.sv
// Program-counter sequencer bus: control inputs from the fetch controller and
// the PC / return-stack status driven back by the sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    logic [2:0]        op;
    logic              stall;
    logic [ADDR_W-1:0] tgt_addr;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] pc_addr;
    logic [SP_W-1:0]   sp;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output op, stall, tgt_addr, offset,
        input  pc_addr, sp, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  op, stall, tgt_addr, offset,
        output pc_addr, sp, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter sequencer with a return-address stack for CALL/RET.
// Stack overflow/underflow is refused (state held) and flagged in a sticky
// error bit that only reset or CLEAR removes.
module pc_seq #(
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_seq_if.slave   bus
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
    localparam logic [2:0] OP_CLEAR  = 3'b110;

    localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_r;
    logic [SP_W-1:0]   sp_r;
    logic              err_r;
    logic [ADDR_W-1:0] stack_r [DEPTH];

    logic [ADDR_W-1:0] pc_nxt_s;
    logic [SP_W-1:0]   sp_nxt_s;
    logic              err_nxt_s;
    logic              push_s;
    logic              full_s;
    logic              empty_s;
    logic [ADDR_W-1:0] ret_addr_s;
    logic [IDX_W-1:0]  pop_idx_s;

    assign full_s     = (sp_r == SP_FULL);
    assign empty_s    = (sp_r == '0);
    assign ret_addr_s = pc_r + PC_ONE;
    // Top valid entry; only dereferenced when the stack is non-empty.
    assign pop_idx_s  = IDX_W'(sp_r - SP_ONE);

    // Decode the op into next PC, stack pointer, error flag and push strobe.
    always_comb begin
        pc_nxt_s  = pc_r;
        sp_nxt_s  = sp_r;
        err_nxt_s = err_r;
        push_s    = 1'b0;
        if (!bus.stall) begin
            case (bus.op)
                OP_HOLD: begin
                    pc_nxt_s = pc_r;
                end
                OP_INC: begin
                    pc_nxt_s = pc_r + PC_ONE;
                end
                OP_JUMP: begin
                    pc_nxt_s = bus.tgt_addr;
                end
                OP_BRANCH: begin
                    pc_nxt_s = pc_r + bus.offset;
                end
                OP_CALL: begin
                    if (!full_s) begin
                        push_s   = 1'b1;
                        pc_nxt_s = bus.tgt_addr;
                        sp_nxt_s = sp_r + SP_ONE;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty_s) begin
                        pc_nxt_s = stack_r[pop_idx_s];
                        sp_nxt_s = sp_r - SP_ONE;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    pc_nxt_s  = RESET_VEC;
                    sp_nxt_s  = '0;
                    err_nxt_s = 1'b0;
                end
                default: begin
                    pc_nxt_s = pc_r;
                end
            endcase
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r  <= RESET_VEC;
            sp_r  <= '0;
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            sp_r  <= sp_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // Return-address RAM write; contents are never reset, and reset blocks a push.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            stack_r[sp_r[IDX_W-1:0]] <= ret_addr_s;
        end
    end

    assign bus.pc_addr     = pc_r;
    assign bus.sp          = sp_r;
    assign bus.stack_err   = err_r;
    assign bus.stack_full  = full_s;
    assign bus.stack_empty = empty_s;
endmodule

// File: tb/tb_pc_seq.sv
// Directed testbench for pc_seq (ADDR_W=16, DEPTH=8, RESET_VEC=0).
module tb_pc_seq;
    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JUMP = 3'b010, BRANCH = 3'b011;
    localparam logic [2:0] CALL = 3'b100, RET = 3'b101, CLEAR = 3'b110, RSVD = 3'b111;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pc_seq_if #(.ADDR_W(16), .DEPTH(8)) bus ();

    pc_seq #(.ADDR_W(16), .DEPTH(8), .RESET_VEC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one op for one clock edge and sample 1 time unit after the edge.
    task automatic step(input logic [2:0] o, input logic s, input logic [15:0] t, input logic [15:0] f);
        bus.op       = o;
        bus.stall    = s;
        bus.tgt_addr = t;
        bus.offset   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc, input logic [3:0] spv, input logic err);
        check_eq({tag, ".pc"},  {16'h0000, bus.pc_addr}, {16'h0000, pc});
        check_eq({tag, ".sp"},  {28'h0, bus.sp}, {28'h0, spv});
        check_eq({tag, ".err"}, {31'h0, bus.stack_err}, {31'h0, err});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        step(HOLD, 1'b0, 16'h0000, 16'h0000);
        step(HOLD, 1'b0, 16'h0000, 16'h0000);
        check_state("reset", 16'h0000, 4'd0, 1'b0);
        check_eq("reset.full",  {31'h0, bus.stack_full},  32'd0);
        check_eq("reset.empty", {31'h0, bus.stack_empty}, 32'd1);
        rst_n = 1'b1;

        // Five increments from the reset vector.
        for (int i = 1; i <= 5; i++) begin
            step(INC, 1'b0, 16'h0000, 16'h0000);
            check_state($sformatf("inc%0d", i), 16'(i), 4'd0, 1'b0);
        end

        // Wrap-around on increment and on branch.
        step(JUMP, 1'b0, 16'hFFFE, 16'h0000); check_state("jump_fffe", 16'hFFFE, 4'd0, 1'b0);
        step(INC, 1'b0, 16'h0000, 16'h0000);  check_state("inc_ffff", 16'hFFFF, 4'd0, 1'b0);
        step(INC, 1'b0, 16'h0000, 16'h0000);  check_state("inc_wrap", 16'h0000, 4'd0, 1'b0);
        step(JUMP, 1'b0, 16'h0010, 16'h0000); check_state("jump_0010", 16'h0010, 4'd0, 1'b0);
        step(BRANCH, 1'b0, 16'h0000, 16'hFFF0); check_state("br_neg", 16'h0000, 4'd0, 1'b0);
        step(BRANCH, 1'b0, 16'h0000, 16'h0000); check_state("br_zero", 16'h0000, 4'd0, 1'b0);
        step(BRANCH, 1'b0, 16'h0000, 16'h0005); check_state("br_pos", 16'h0005, 4'd0, 1'b0);
        step(HOLD, 1'b0, 16'h7777, 16'h0003);   check_state("hold", 16'h0005, 4'd0, 1'b0);
        step(RSVD, 1'b0, 16'h7777, 16'h0003);   check_state("rsvd", 16'h0005, 4'd0, 1'b0);

        // Nested call / return.
        step(JUMP, 1'b0, 16'h0100, 16'h0000); check_state("jump_0100", 16'h0100, 4'd0, 1'b0);
        step(CALL, 1'b0, 16'h0200, 16'h0000); check_state("call1", 16'h0200, 4'd1, 1'b0);
        step(CALL, 1'b0, 16'h0300, 16'h0000); check_state("call2", 16'h0300, 4'd2, 1'b0);
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("ret1", 16'h0201, 4'd1, 1'b0);
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("ret2", 16'h0101, 4'd0, 1'b0);
        check_eq("ret2.empty", {31'h0, bus.stack_empty}, 32'd1);

        // Fill the stack, then overflow.
        for (int i = 0; i < 8; i++) begin
            step(CALL, 1'b0, 16'h1000 + 16'(i), 16'h0000);
            check_state($sformatf("fill%0d", i), 16'h1000 + 16'(i), 4'(i + 1), 1'b0);
        end
        check_eq("fill.full", {31'h0, bus.stack_full}, 32'd1);
        step(CALL, 1'b0, 16'h0AAA, 16'h0000); check_state("overflow", 16'h1007, 4'd8, 1'b1);
        step(CLEAR, 1'b1, 16'h0000, 16'h0000); check_state("stall_clear", 16'h1007, 4'd8, 1'b1);
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("ret_top", 16'h1007, 4'd7, 1'b1);
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("ret_next", 16'h1006, 4'd6, 1'b1);
        step(CLEAR, 1'b0, 16'h0000, 16'h0000); check_state("clear", 16'h0000, 4'd0, 1'b0);
        check_eq("clear.full", {31'h0, bus.stack_full}, 32'd0);

        // Underflow and stall.
        step(JUMP, 1'b0, 16'h0042, 16'h0000); check_state("jump_0042", 16'h0042, 4'd0, 1'b0);
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("underflow", 16'h0042, 4'd0, 1'b1);
        step(JUMP, 1'b1, 16'h1234, 16'h0000); check_state("stall_jump", 16'h0042, 4'd0, 1'b1);
        step(CALL, 1'b1, 16'h5555, 16'h0000); check_state("stall_call", 16'h0042, 4'd0, 1'b1);
        step(JUMP, 1'b0, 16'h1234, 16'h0000); check_state("release", 16'h1234, 4'd0, 1'b1);

        // Reset wins over a CALL on the same edge; no entry is pushed.
        step(CALL, 1'b0, 16'h0AAA, 16'h0000);  check_state("pre_rst_call", 16'h0AAA, 4'd1, 1'b1);
        rst_n = 1'b0;
        step(CALL, 1'b0, 16'h0777, 16'h0000); check_state("rst_call", 16'h0000, 4'd0, 1'b0);
        rst_n = 1'b1;
        step(RET, 1'b0, 16'h0000, 16'h0000);  check_state("rst_nopush", 16'h0000, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
